// File: rtl/instr_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder_if
// Brief    : Field-bundle input stream and encoded-word output stream of the
//            instruction encoder.
// Revision : 1.0  initial release
// ============================================================================
interface instr_encoder_if #(
    parameter int OPW  = 5,
    parameter int REGW = 3,
    parameter int AW   = 8
);
    logic            in_valid;
    logic            in_ready;
    logic            in_mode;
    logic [OPW-1:0]  in_opcode;
    logic [REGW-1:0] in_reg1;
    logic [REGW-1:0] in_reg2;
    logic [7:0]      in_imm;

    logic            out_valid;
    logic            out_ready;
    logic [8:0]      out_code;
    logic            out_mode;
    logic [AW-1:0]   out_addr;

    modport master (
        output in_valid, in_mode, in_opcode, in_reg1, in_reg2, in_imm, out_ready,
        input  in_ready, out_valid, out_code, out_mode, out_addr
    );

    modport slave (
        input  in_valid, in_mode, in_opcode, in_reg1, in_reg2, in_imm, out_ready,
        output in_ready, out_valid, out_code, out_mode, out_addr
    );
endinterface
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder
// Brief    : Packs decoded fields into 9-bit machine words with sequential
//            program addresses; rejects and counts unencodable bundles.
// Revision : 1.0  initial release
// ============================================================================
module instr_encoder #(
    parameter int OPW  = 5,
    parameter int REGW = 3,
    parameter int AW   = 8
) (
    input  wire logic           Clk,
    input  wire logic           Reset_n,
    input  wire logic           start,
    input  wire logic           finish,
    instr_encoder_if.slave      bus,
    output logic                err_pulse,
    output logic [1:0]          err_code,
    output logic [7:0]          err_count,
    output logic [AW:0]         word_count,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0]    c_err_none = 2'd0;
    localparam logic [1:0]    c_err_reg  = 2'd1;
    localparam logic [1:0]    c_err_op   = 2'd2;
    localparam logic [1:0]    c_err_imm  = 2'd3;
    localparam logic [AW-1:0] c_addr_one = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   c_wc_one   = {{AW{1'b0}}, 1'b1};

    state_t        state_q,     state_d;
    logic          out_valid_q, out_valid_d;
    logic [8:0]    out_code_q,  out_code_d;
    logic          out_mode_q,  out_mode_d;
    logic [AW-1:0] out_addr_q,  out_addr_d;
    logic          err_pulse_q, err_pulse_d;
    logic [1:0]    err_code_q,  err_code_d;
    logic [7:0]    err_count_q, err_count_d;
    logic [AW:0]   word_cnt_q,  word_cnt_d;
    logic          busy_q,      busy_d;
    logic          done_q,      done_d;

    logic          w_in_ready;
    logic          w_in_fire;
    logic          w_out_fire;
    logic [8:0]    w_enc_code;
    logic [1:0]    w_enc_err;
    logic [2:0]    w_imm_idx;
    logic          w_imm_ok;

    // Only the eight powers-of-two-ish immediates have a 3-bit index.
    always_comb begin
        w_imm_idx = 3'd0;
        w_imm_ok  = 1'b1;
        case (bus.in_imm)
            8'd0:    w_imm_idx = 3'd0;
            8'd1:    w_imm_idx = 3'd1;
            8'd4:    w_imm_idx = 3'd2;
            8'd8:    w_imm_idx = 3'd3;
            8'd16:   w_imm_idx = 3'd4;
            8'd32:   w_imm_idx = 3'd5;
            8'd64:   w_imm_idx = 3'd6;
            8'd127:  w_imm_idx = 3'd7;
            default: w_imm_ok  = 1'b0;
        endcase
    end

    always_comb begin
        w_enc_code = 9'd0;
        w_enc_err  = c_err_none;
        if (!bus.in_mode) begin
            w_enc_code = {bus.in_opcode[4:0], bus.in_reg1[1:0], bus.in_reg2[1:0]};
            if (bus.in_reg1[2] || bus.in_reg2[2]) begin
                w_enc_err = c_err_reg;
            end
        end else begin
            w_enc_code = {bus.in_opcode[2:0], bus.in_reg1[2:0], w_imm_idx};
            if (bus.in_opcode[4:3] != 2'b00) begin
                w_enc_err = c_err_op;
            end else if (!w_imm_ok) begin
                w_enc_err = c_err_imm;
            end
        end
    end

    assign w_in_ready = (state_q == S_RUN) && (!out_valid_q || bus.out_ready)
                        && !word_cnt_q[AW];
    assign w_in_fire  = bus.in_valid && w_in_ready;
    assign w_out_fire = out_valid_q && bus.out_ready;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_code_d  = out_code_q;
        out_mode_d  = out_mode_q;
        out_addr_d  = out_addr_q;
        err_pulse_d = 1'b0;
        err_code_d  = err_code_q;
        err_count_d = err_count_q;
        word_cnt_d  = word_cnt_q;

        if (w_out_fire) begin
            out_valid_d = 1'b0;
            out_addr_d  = out_addr_q + c_addr_one;
        end

        case (state_q)
            S_IDLE:  state_d = S_IDLE;
            S_RUN:   if (finish) state_d = S_DRAIN;
            S_DRAIN: if (!out_valid_q || bus.out_ready) state_d = S_DONE;
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase

        // A restart wipes the program; a bundle accepted on the same edge
        // becomes the first word of the new program.
        if (start) begin
            state_d     = S_RUN;
            out_valid_d = 1'b0;
            out_addr_d  = '0;
            word_cnt_d  = '0;
            err_code_d  = c_err_none;
            err_count_d = 8'd0;
        end

        if (w_in_fire) begin
            if (w_enc_err == c_err_none) begin
                out_valid_d = 1'b1;
                out_code_d  = w_enc_code;
                out_mode_d  = bus.in_mode;
                word_cnt_d  = word_cnt_d + c_wc_one;
            end else begin
                err_pulse_d = 1'b1;
                err_code_d  = w_enc_err;
                if (err_count_d != 8'hFF) begin
                    err_count_d = err_count_d + 8'd1;
                end
            end
        end

        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            out_code_q  <= 9'd0;
            out_mode_q  <= 1'b0;
            out_addr_q  <= '0;
            err_pulse_q <= 1'b0;
            err_code_q  <= 2'd0;
            err_count_q <= 8'd0;
            word_cnt_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_code_q  <= out_code_d;
            out_mode_q  <= out_mode_d;
            out_addr_q  <= out_addr_d;
            err_pulse_q <= err_pulse_d;
            err_code_q  <= err_code_d;
            err_count_q <= err_count_d;
            word_cnt_q  <= word_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_code  = out_code_q;
    assign bus.out_mode  = out_mode_q;
    assign bus.out_addr  = out_addr_q;
    assign err_pulse     = err_pulse_q;
    assign err_code      = err_code_q;
    assign err_count     = err_count_q;
    assign word_count    = word_cnt_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_encoder
// Brief    : Table-driven scoreboard bench for instr_encoder.
// Revision : 1.0  initial release
// ============================================================================
module tb_instr_encoder;
    localparam int OPW  = 5;
    localparam int REGW = 3;
    localparam int AW   = 8;

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          start = 1'b0;
    logic          finish = 1'b0;
    logic          err_pulse;
    logic [1:0]    err_code;
    logic [7:0]    err_count;
    logic [AW:0]   word_count;
    logic          busy;
    logic          done;

    instr_encoder_if #(.OPW(OPW), .REGW(REGW), .AW(AW)) bus ();

    instr_encoder #(.OPW(OPW), .REGW(REGW), .AW(AW)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .start      (start),
        .finish     (finish),
        .bus        (bus.slave),
        .err_pulse  (err_pulse),
        .err_code   (err_code),
        .err_count  (err_count),
        .word_count (word_count),
        .busy       (busy),
        .done       (done)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic       mode;
        logic [4:0] op;
        logic [2:0] r1;
        logic [2:0] r2;
        logic [7:0] imm;
        logic [1:0] ecode;
        logic [8:0] code;
    } vec_t;

    typedef struct {
        logic          is_err;
        logic [8:0]    code;
        logic          mode;
        logic [AW-1:0] addr;
        logic [1:0]    ecode;
        logic [7:0]    ecount;
    } exp_t;

    exp_t          q[$];
    vec_t          tbl[18];
    int            n_cmp = 0;
    int            n_bad = 0;
    logic [AW-1:0] m_addr = '0;
    logic [7:0]    m_errs = 8'd0;
    int            m_wc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.in_mode   = v.mode;
        bus.in_opcode = v.op;
        bus.in_reg1   = v.r1;
        bus.in_reg2   = v.r2;
        bus.in_imm    = v.imm;
    endtask

    task automatic push_exp(input vec_t v);
        exp_t e;
        if (v.ecode != 2'd0) begin
            if (m_errs != 8'hFF) m_errs++;
            e = '{1'b1, 9'd0, 1'b0, '0, v.ecode, m_errs};
        end else begin
            e = '{1'b0, v.code, v.mode, m_addr, 2'd0, 8'd0};
            m_addr++;
            m_wc++;
        end
        q.push_back(e);
    endtask

    // Entered and left at posedge+1; waited = cycles spent before acceptance.
    task automatic send(input vec_t v, input logic fin, output int waited);
        drive(v);
        bus.in_valid = 1'b1;
        finish       = fin;
        waited       = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge Clk);
            if (bus.in_ready) begin
                waited = k;
                push_exp(v);
                @(posedge Clk); #1;
                break;
            end
            @(posedge Clk); #1;
        end
        bus.in_valid = 1'b0;
        finish       = 1'b0;
        if (waited < 0) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge Clk); #1;
        start  = 1'b0;
        m_addr = '0;
        m_errs = 8'd0;
        m_wc   = 0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 30 && (q.size() != 0 || bus.out_valid); k++) @(negedge Clk);
        chk("drain_queue_empty", q.size(), 32'd0);
        @(posedge Clk); #1;
    endtask

    always @(negedge Clk) begin
        exp_t e;
        if (Reset_n) begin
            if (!start && bus.out_valid && bus.out_ready) begin
                if (q.size() == 0 || q[0].is_err) begin
                    chk("word_unexpected", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("word_code", bus.out_code, e.code);
                    chk("word_mode", bus.out_mode, e.mode);
                    chk("word_addr", bus.out_addr, e.addr);
                end
            end
            if (err_pulse) begin
                if (q.size() == 0 || !q[0].is_err) begin
                    chk("err_unexpected", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("err_code", err_code, e.ecode);
                    chk("err_count", err_count, e.ecount);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int        w;
        logic [AW-1:0] a_hold;

        tbl[0]  = '{1'b0, 5'b10110, 3'd2, 3'd3, 8'd0,   2'd0, 9'b101101011};
        tbl[1]  = '{1'b0, 5'b00001, 3'd1, 3'd0, 8'd0,   2'd0, 9'b000010100};
        tbl[2]  = '{1'b1, 5'd3,     3'd5, 3'd0, 8'd16,  2'd0, 9'b011101100};
        tbl[3]  = '{1'b1, 5'd3,     3'd5, 3'd0, 8'd127, 2'd0, 9'b011101111};
        tbl[4]  = '{1'b1, 5'd7,     3'd0, 3'd0, 8'd0,   2'd0, 9'b111000000};
        tbl[5]  = '{1'b1, 5'd0,     3'd7, 3'd0, 8'd1,   2'd0, 9'b000111001};
        tbl[6]  = '{1'b1, 5'd1,     3'd2, 3'd0, 8'd4,   2'd0, 9'b001010010};
        tbl[7]  = '{1'b1, 5'd2,     3'd3, 3'd0, 8'd8,   2'd0, 9'b010011011};
        tbl[8]  = '{1'b1, 5'd4,     3'd6, 3'd0, 8'd32,  2'd0, 9'b100110101};
        tbl[9]  = '{1'b1, 5'd5,     3'd1, 3'd0, 8'd64,  2'd0, 9'b101001110};
        tbl[10] = '{1'b1, 5'd3,     3'd5, 3'd0, 8'd5,   2'd3, 9'd0};
        tbl[11] = '{1'b1, 5'd8,     3'd0, 3'd0, 8'd3,   2'd2, 9'd0};
        tbl[12] = '{1'b0, 5'd0,     3'd0, 3'd4, 8'd0,   2'd1, 9'd0};
        tbl[13] = '{1'b0, 5'd31,    3'd3, 3'd3, 8'd0,   2'd0, 9'b111111111};
        tbl[14] = '{1'b1, 5'd3,     3'd1, 3'd0, 8'd128, 2'd3, 9'd0};
        tbl[15] = '{1'b0, 5'd24,    3'd4, 3'd0, 8'd0,   2'd1, 9'd0};
        tbl[16] = '{1'b1, 5'd16,    3'd2, 3'd0, 8'd16,  2'd2, 9'd0};
        tbl[17] = '{1'b1, 5'd1,     3'd1, 3'd7, 8'd0,   2'd0, 9'b001001000};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive(tbl[0]);

        // Reset state; a valid bundle in IDLE must not be taken.
        repeat (3) @(posedge Clk);
        #1 Reset_n = 1'b1;
        bus.in_valid = 1'b1;
        @(negedge Clk);
        chk("rst_out_valid", bus.out_valid, 32'd0);
        chk("rst_out_code", bus.out_code, 32'd0);
        chk("rst_out_addr", bus.out_addr, 32'd0);
        chk("rst_err_count", err_count, 32'd0);
        chk("rst_word_count", word_count, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("idle_in_ready", bus.in_ready, 32'd0);
        @(posedge Clk); #1;
        bus.in_valid = 1'b0;

        do_start();
        @(negedge Clk);
        chk("run_busy", busy, 32'd1);
        chk("run_in_ready", bus.in_ready, 32'd1);
        @(posedge Clk); #1;

        for (int i = 0; i < 18; i++) send(tbl[i], 1'b0, w);
        wait_drain();
        chk("tbl_word_count", word_count, m_wc);
        chk("tbl_err_count", err_count, m_errs);

        // Backpressure: word held stable, then replaced on the releasing edge.
        bus.out_ready = 1'b0;
        send(tbl[0], 1'b0, w);
        a_hold = m_addr - 1'b1;
        drive(tbl[2]);
        bus.in_valid = 1'b1;
        repeat (3) begin
            @(negedge Clk);
            chk("stall_in_ready", bus.in_ready, 32'd0);
            chk("stall_code", bus.out_code, tbl[0].code);
            chk("stall_addr", bus.out_addr, a_hold);
        end
        @(posedge Clk); #1;
        bus.out_ready = 1'b1;
        send(tbl[2], 1'b0, w);
        chk("stall_release_same_cycle", w, 32'd0);
        wait_drain();

        // finish together with an accepted bundle; DRAIN waits for the word.
        bus.out_ready = 1'b0;
        send(tbl[4], 1'b1, w);
        chk("finish_accept", w, 32'd0);
        repeat (2) begin
            @(negedge Clk);
            chk("drain_busy", busy, 32'd1);
            chk("drain_done", done, 32'd0);
            chk("drain_pending", bus.out_valid, 32'd1);
        end
        @(posedge Clk); #1;
        bus.out_ready = 1'b1;
        @(posedge Clk); #1;
        @(negedge Clk);
        chk("done_after_drain", done, 32'd1);
        chk("done_not_busy", busy, 32'd0);
        @(posedge Clk); #1;

        // Restart with a word pending drops it and clears the counters.
        do_start();
        bus.out_ready = 1'b0;
        send(tbl[0], 1'b0, w);
        @(negedge Clk);
        chk("pre_restart_valid", bus.out_valid, 32'd1);
        @(posedge Clk); #1;
        do_start();
        q.delete();
        @(negedge Clk);
        chk("restart_valid", bus.out_valid, 32'd0);
        chk("restart_addr", bus.out_addr, 32'd0);
        chk("restart_wc", word_count, 32'd0);
        chk("restart_err_code", err_code, 32'd0);
        chk("restart_busy", busy, 32'd1);
        @(posedge Clk); #1;

        // Fill to capacity, then finish and restart.
        bus.out_ready = 1'b1;
        for (int i = 0; i < (1 << AW); i++) send(tbl[0], 1'b0, w);
        drive(tbl[0]);
        bus.in_valid = 1'b1;
        repeat (2) begin
            @(negedge Clk);
            chk("full_in_ready", bus.in_ready, 32'd0);
            chk("full_wc", word_count, m_wc);
        end
        @(posedge Clk); #1;
        bus.in_valid = 1'b0;
        finish = 1'b1;
        @(posedge Clk); #1;
        finish = 1'b0;
        @(negedge Clk);
        chk("full_drain_busy", busy, 32'd1);
        chk("full_drain_done", done, 32'd0);
        @(negedge Clk);
        chk("full_done", done, 32'd1);
        chk("full_done_busy", busy, 32'd0);
        chk("full_queue_empty", q.size(), 32'd0);
        @(posedge Clk); #1;
        do_start();
        @(negedge Clk);
        chk("full_restart_addr", bus.out_addr, 32'd0);
        chk("full_restart_wc", word_count, 32'd0);
        chk("full_restart_done", done, 32'd0);
        chk("full_restart_ready", bus.in_ready, 32'd1);
        @(posedge Clk); #1;

        // Reset with a word pending.
        bus.out_ready = 1'b0;
        send(tbl[2], 1'b0, w);
        @(negedge Clk);
        chk("pre_reset_valid", bus.out_valid, 32'd1);
        @(posedge Clk); #1;
        Reset_n = 1'b0;
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        q.delete();
        drive(tbl[0]);
        bus.in_valid = 1'b1;
        repeat (2) begin
            @(negedge Clk);
            chk("mid_rst_valid", bus.out_valid, 32'd0);
            chk("mid_rst_code", bus.out_code, 32'd0);
            chk("mid_rst_addr", bus.out_addr, 32'd0);
            chk("mid_rst_wc", word_count, 32'd0);
            chk("mid_rst_busy", busy, 32'd0);
            chk("mid_rst_in_ready", bus.in_ready, 32'd0);
        end
        bus.in_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
